// File: rtl/morse_pkg.sv
// Shared Morse link constants: symbol timing, decode thresholds, digit table, FSM states.
package morse_pkg;

    // Encoder-side timing, in units
    localparam int MORSE_DOT_UNITS      = 1;
    localparam int MORSE_DASH_UNITS     = 3;
    localparam int MORSE_CHAR_GAP_UNITS = 3;
    localparam int MORSE_WORD_GAP_UNITS = 7;

    // Decoder thresholds, in units: mark >= 2 is a dash, space >= 2 ends a
    // character, space >= 5 ends a word, mark >= 5 is malformed.
    localparam int MORSE_DASH_THRESH_UNITS = 2;
    localparam int MORSE_WORD_THRESH_UNITS = 5;

    localparam int MORSE_SYMS = 5;

    // Digit patterns, MSB = first symbol, 1 = dash. Index = digit value.
    localparam logic [9:0][MORSE_SYMS-1:0] MORSE_DIGIT_PAT = {
        5'b11110,   // 9
        5'b11100,   // 8
        5'b11000,   // 7
        5'b10000,   // 6
        5'b00000,   // 5
        5'b00001,   // 4
        5'b00011,   // 3
        5'b00111,   // 2
        5'b01111,   // 1
        5'b11111    // 0
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2
    } morse_state_e;

endpackage

// File: rtl/morse_digit_lookup.sv
// Combinational match of a completed 5-symbol character against the digit table.
module morse_digit_lookup
    import morse_pkg::*;
(
    input  logic [4:0] sym,
    input  logic [2:0] sym_cnt,
    output logic [3:0] digit,
    output logic       valid
);

    // Only a character of exactly five symbols can be a digit
    always_comb begin
        digit = 4'd0;
        valid = 1'b0;
        if (sym_cnt == 3'd5) begin
            for (int i = 0; i < 10; i++) begin
                if (sym == MORSE_DIGIT_PAT[i]) begin
                    digit = 4'(i);
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/morse_decoder.sv
// Morse receive path: times marks/spaces on a synchronized line, decodes
// digits MSB-first into a binary word, and emits it on an inter-word gap.
module morse_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4800000,
    parameter int WIDTH       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] value_o,
    output logic             valid_o,
    output logic             err_o,
    output logic             busy_o
);

    localparam int T2 = MORSE_DASH_THRESH_UNITS * UNIT_CYCLES;
    localparam int T5 = MORSE_WORD_THRESH_UNITS * UNIT_CYCLES;
    localparam int DW = $clog2(T5 + 1);
    localparam logic [DW-1:0] T2_D  = DW'(T2);
    localparam logic [DW-1:0] T5_D  = DW'(T5);
    localparam logic [DW-1:0] ONE_D = DW'(1);

    logic [1:0]       sync_q;
    logic             s;
    morse_state_e     state, state_n;
    logic [DW-1:0]    dur, dur_n, dur_inc;
    logic [4:0]       sym, sym_n;
    logic [2:0]       sym_cnt, sym_cnt_n;
    logic [WIDTH-1:0] acc, acc_n, value_n;
    logic             word_err, word_err_n, valid_n, err_n;
    logic [3:0]       digit;
    logic             digit_ok;
    logic [WIDTH+3:0] acc_ext, acc_next;

    assign s       = sync_q[1];
    assign busy_o  = (state != IDLE);
    assign dur_inc = (dur == T5_D) ? dur : dur + ONE_D;

    // acc*10 + d with four guard bits to catch overflow
    assign acc_ext  = {4'b0, acc};
    assign acc_next = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, digit};

    morse_digit_lookup u_lookup (
        .sym     (sym),
        .sym_cnt (sym_cnt),
        .digit   (digit),
        .valid   (digit_ok)
    );

    // Two-flop synchronizer for the asynchronous Morse line
    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], serial_i};
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state, timing classification, character commit and word emit
    always_comb begin
        state_n    = state;
        dur_n      = dur_inc;
        sym_n      = sym;
        sym_cnt_n  = sym_cnt;
        acc_n      = acc;
        word_err_n = word_err;
        value_n    = value_o;
        valid_n    = 1'b0;
        err_n      = err_o;
        unique case (state)
            IDLE: begin
                dur_n = '0;
                if (s) begin
                    state_n = MARK;
                    dur_n   = ONE_D;
                end
            end
            MARK: begin
                if (!s) begin
                    // Over-long marks still shift a dash so symbol counting stays sane
                    if (dur >= T5_D) word_err_n = 1'b1;
                    sym_n = {sym[3:0], (dur >= T2_D)};
                    if (sym_cnt >= 3'd5) begin
                        word_err_n = 1'b1;
                        sym_cnt_n  = 3'd6;
                    end else begin
                        sym_cnt_n = sym_cnt + 3'd1;
                    end
                    state_n = SPACE;
                    dur_n   = ONE_D;
                end
            end
            SPACE: begin
                // Character boundary: commit exactly once, even if a mark starts now
                if (dur == T2_D) begin
                    if (digit_ok) begin
                        acc_n = acc_next[WIDTH-1:0];
                        if (|acc_next[WIDTH+3:WIDTH]) word_err_n = 1'b1;
                    end else begin
                        word_err_n = 1'b1;
                    end
                    sym_n     = '0;
                    sym_cnt_n = '0;
                end
                if (dur == T5_D) begin
                    value_n    = acc;
                    err_n      = word_err;
                    valid_n    = 1'b1;
                    acc_n      = '0;
                    word_err_n = 1'b0;
                    state_n    = s ? MARK : IDLE;
                    dur_n      = s ? ONE_D : '0;
                end else if (s) begin
                    state_n = MARK;
                    dur_n   = ONE_D;
                end
            end
            default: begin
                state_n = IDLE;
                dur_n   = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dur      <= '0;
            sym      <= '0;
            sym_cnt  <= '0;
            acc      <= '0;
            word_err <= 1'b0;
            value_o  <= '0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            dur      <= dur_n;
            sym      <= sym_n;
            sym_cnt  <= sym_cnt_n;
            acc      <= acc_n;
            word_err <= word_err_n;
            value_o  <= value_n;
            valid_o  <= valid_n;
            err_o    <= err_n;
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized bench for morse_decoder: two widths share one Morse line; a
// digit-string reference model predicts each emitted word.
module tb_morse_decoder;

    localparam int U = 4;

    typedef struct {
        logic [31:0] v;
        logic        e;
        int          c;
        logic        b;
    } ev_t;

    logic        clk, rst, serial;
    logic [31:0] value32;
    logic [7:0]  value8;
    logic        valid32, err32, busy32, valid8, err8, busy8;

    int  n_chk = 0, n_fail = 0;
    int  cyc = 0, last_fall = 0;
    bit  fixed = 0;
    logic pv32 = 0, pv8 = 0;
    ev_t  q32[$], q8[$];
    string cur[$];
    string pats[10] = '{"-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

    morse_decoder #(.UNIT_CYCLES(U), .WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .serial_i(serial),
        .value_o(value32), .valid_o(valid32), .err_o(err32), .busy_o(busy32));

    morse_decoder #(.UNIT_CYCLES(U), .WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .serial_i(serial),
        .value_o(value8), .valid_o(valid8), .err_o(err8), .busy_o(busy8));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Capture every emitted word; a pulse right after another is an error
    always @(negedge clk) begin
        if (valid32) begin
            chk("valid32_back_to_back", pv32, 0);
            q32.push_back('{v: value32, e: err32, c: cyc, b: busy32});
        end
        if (valid8) begin
            chk("valid8_back_to_back", pv8, 0);
            q8.push_back('{v: {24'b0, value8}, e: err8, c: cyc, b: busy8});
        end
        pv32 = valid32;
        pv8  = valid8;
    end

    // 'a' = dot of 7 cycles, 'b' = dash of 8 cycles, '!' = over-long mark
    function automatic byte norm(input byte c);
        if (c == "a") return ".";
        if (c == "b" || c == "!") return "-";
        return c;
    endfunction

    function automatic int decode(input string c);
        string p;
        bit    ok;
        if (c.len() != 5) return -1;
        for (int d = 0; d < 10; d++) begin
            p  = pats[d];
            ok = 1;
            for (int i = 0; i < 5; i++)
                if (norm(c[i]) != p[i]) ok = 0;
            if (ok) return d;
        end
        return -1;
    endfunction

    function automatic bit has_long(input string c);
        for (int i = 0; i < c.len(); i++)
            if (c[i] == "!") return 1;
        return 0;
    endfunction

    function automatic int sym_len(input byte c);
        case (c)
            "a":     return 7;
            "b":     return 8;
            ".":     return fixed ? U     : int'($urandom_range(1, 2*U-1));
            "-":     return fixed ? 3*U   : int'($urandom_range(2*U, 5*U-1));
            default: return fixed ? 5*U   : int'($urandom_range(5*U, 5*U+4));
        endcase
    endfunction

    task automatic load_digits(input string ds);
        cur.delete();
        for (int i = 0; i < ds.len(); i++) cur.push_back(pats[ds[i] - "0"]);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_value32"}, value32, 0);
        chk({tag, "_valid32"}, valid32, 0);
        chk({tag, "_err32"},   err32,   0);
        chk({tag, "_busy32"},  busy32,  0);
        chk({tag, "_value8"},  value8,  0);
        chk({tag, "_busy8"},   busy8,   0);
    endtask

    // Send the word in cur, then check both decoders against the model
    task automatic play_word();
        longint unsigned a32, a8;
        bit   e32, e8, vdef, last;
        int   d, len, gap;
        string c;
        ev_t  ev;
        a32 = 0; a8 = 0; e32 = 0; e8 = 0; vdef = 1;
        foreach (cur[ci]) begin
            d = decode(cur[ci]);
            if (has_long(cur[ci])) begin e32 = 1; e8 = 1; vdef = 0; end
            if (d < 0) begin
                e32 = 1; e8 = 1;
            end else begin
                a32 = a32 * 10 + longint'(d);
                if (a32 > 64'hFFFF_FFFF) begin e32 = 1; a32 = a32 & 64'hFFFF_FFFF; end
                a8 = a8 * 10 + longint'(d);
                if (a8 > 255) begin e8 = 1; a8 = a8 & 255; end
            end
        end
        foreach (cur[ci]) begin
            c = cur[ci];
            for (int si = 0; si < c.len(); si++) begin
                len  = sym_len(c[si]);
                last = (ci == cur.size() - 1) && (si == c.len() - 1);
                if (last)                gap = fixed ? 10*U : int'($urandom_range(25, 32));
                else if (si == c.len()-1) gap = fixed ? 3*U  : int'($urandom_range(2*U, 5*U-1));
                else                     gap = fixed ? U    : int'($urandom_range(1, 2*U-1));
                serial = 1;
                repeat (len) @(negedge clk);
                serial = 0;
                last_fall = cyc + 1;
                if (last) begin
                    repeat (3) @(negedge clk);
                    chk("busy32_in_word", busy32, 1);
                    chk("busy8_in_word",  busy8,  1);
                    repeat (gap - 3) @(negedge clk);
                end else begin
                    repeat (gap) @(negedge clk);
                end
            end
        end
        chk("pulses32", q32.size(), 1);
        if (q32.size() > 0) begin
            ev = q32.pop_front();
            if (vdef) chk("value32", ev.v, a32);
            chk("err32", ev.e, e32);
            chk("latency32", ev.c - last_fall, 22);
            chk("busy32_at_valid", ev.b, 0);
        end
        chk("pulses8", q8.size(), 1);
        if (q8.size() > 0) begin
            ev = q8.pop_front();
            if (vdef) chk("value8", ev.v, a8);
            chk("err8", ev.e, e8);
            chk("latency8", ev.c - last_fall, 22);
        end
        q32.delete();
        q8.delete();
    endtask

    initial begin
        string m;
        int    r;
        rst = 1; serial = 0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 0;
        @(negedge clk);

        // Nominal timing, then separate words
        fixed = 1;
        load_digits("42");  play_word();
        load_digits("0");   play_word();
        load_digits("907"); play_word();
        fixed = 0;

        // Mark length boundaries: 7 -> dot, 8 -> dash, long mark -> error
        cur.delete(); cur.push_back("abbbb"); cur.push_back("a...."); play_word();
        fixed = 1;
        cur.delete(); cur.push_back("-!---"); play_word();
        fixed = 0;

        // Malformed character, then recovery
        cur.delete(); cur.push_back(".-"); play_word();
        load_digits("5"); play_word();

        // Overflow boundaries for both widths
        load_digits("300");        play_word();
        load_digits("255");        play_word();
        load_digits("4294967295"); play_word();
        load_digits("4294967296"); play_word();

        // Reset in the middle of "7" discards the partial word
        fixed = 1;
        serial = 1; repeat (12) @(negedge clk);
        serial = 0; repeat (4)  @(negedge clk);
        serial = 1; repeat (12) @(negedge clk);
        serial = 0; repeat (4)  @(negedge clk);
        serial = 1; repeat (4)  @(negedge clk);
        serial = 0; repeat (5)  @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        check_outputs_zero("mid_reset");
        repeat (30) @(negedge clk);
        chk("no_pulse32_after_reset", q32.size(), 0);
        chk("no_pulse8_after_reset",  q8.size(),  0);
        q32.delete(); q8.delete();
        load_digits("7"); play_word();
        fixed = 0;

        // Random words, mostly digits with occasional malformed characters
        for (int w = 0; w < 30; w++) begin
            cur.delete();
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                if ($urandom_range(0, 9) == 0) begin
                    m = "";
                    for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                        r = $urandom_range(0, 99);
                        if (r < 3)       m = {m, "!"};
                        else if (r < 50) m = {m, "."};
                        else             m = {m, "-"};
                    end
                    cur.push_back(m);
                end else begin
                    cur.push_back(pats[$urandom_range(0, 9)]);
                end
            end
            play_word();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
